// File: rtl/alu_div_pkg.sv
// +----------------------------------------------------------------------+
// | alu_div_pkg : shared types and constants for the iterative divider   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  localparam int                   DIV_WIDTH    = 16;
  localparam int                   DIV_CNT_W    = $clog2(DIV_WIDTH);
  localparam logic [DIV_WIDTH-1:0] DIV_MOST_NEG = 16'h8000;

endpackage

`default_nettype wire

// File: rtl/alu_divider_step.sv
// +----------------------------------------------------------------------+
// | div_step : one combinational restoring shift-subtract iteration      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module div_step
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   partial_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH:0]   partial_out,
  output logic             quotient_bit
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_b;
  logic [WIDTH:0] w_g;
  logic [WIDTH:0] w_p;
  logic [WIDTH:0] w_c;
  logic [WIDTH:0] w_diff;

  assign w_shifted = {partial_in[WIDTH-1:0], dividend_bit};
  assign w_b       = ~{1'b0, divisor_mag};
  assign w_g       = w_shifted & w_b;
  assign w_p       = w_shifted ^ w_b;
  assign w_c[0]    = 1'b1;

  // Generate/propagate carry network in subtract mode (carry-in 1, inverted operand)
  for (genvar i = 0; i < WIDTH; i++) begin : g_carry
    assign w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
  end

  assign w_diff = w_p ^ w_c;

  // A set bit shifted out of the partial means the shifted value already exceeds the divisor
  assign quotient_bit = partial_in[WIDTH] | ~w_diff[WIDTH];
  assign partial_out  = quotient_bit ? w_diff : w_shifted;

endmodule

`default_nettype wire

// File: rtl/alu_divider.sv
// +----------------------------------------------------------------------+
// | alu_divider : iterative signed restoring divider, 1 quotient bit/clk |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_divider
  import alu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int               c_cnt_w    = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] c_most_neg = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t         r_state;
  logic [c_cnt_w-1:0] r_count;
  logic [WIDTH:0]     r_partial;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvs_mag;
  logic               r_sign_q;
  logic               r_sign_r;
  logic               r_ovf;
  logic               r_dbz;

  logic [WIDTH-1:0]   w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;
  logic [WIDTH:0]     w_step_partial;
  logic               w_step_qbit;
  logic [WIDTH-1:0]   w_q_fix;
  logic [WIDTH-1:0]   w_r_fix;

  assign w_dvd_mag = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
  assign w_dvs_mag = divisor[WIDTH-1]  ? (~divisor + WIDTH'(1))  : divisor;
  assign w_q_fix   = r_sign_q ? (~r_quo + WIDTH'(1)) : r_quo;
  assign w_r_fix   = r_sign_r ? (~r_partial[WIDTH-1:0] + WIDTH'(1)) : r_partial[WIDTH-1:0];

  div_step #(.WIDTH(WIDTH)) u_step (
    .partial_in   (r_partial),
    .dividend_bit (r_quo[WIDTH-1]),
    .divisor_mag  (r_dvs_mag),
    .partial_out  (w_step_partial),
    .quotient_bit (w_step_qbit)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_partial   <= '0;
      r_quo       <= '0;
      r_dvs_mag   <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_ovf       <= 1'b0;
      r_dbz       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            r_count   <= '0;
            r_sign_r  <= dividend[WIDTH-1];
            r_dvs_mag <= w_dvs_mag;
            if (divisor == '0) begin
              // Preload FIX so it yields -1 and hands the dividend back as the remainder
              r_partial <= {1'b0, w_dvd_mag};
              r_quo     <= WIDTH'(1);
              r_sign_q  <= 1'b1;
              r_dbz     <= 1'b1;
              r_ovf     <= 1'b0;
              r_state   <= FIX;
            end else begin
              r_partial <= '0;
              r_quo     <= w_dvd_mag;
              r_sign_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              r_dbz     <= 1'b0;
              r_ovf     <= (dividend == c_most_neg) && (divisor == '1);
              r_state   <= RUN;
            end
          end
        end
        RUN: begin
          r_partial <= w_step_partial;
          r_quo     <= {r_quo[WIDTH-2:0], w_step_qbit};
          r_count   <= r_count + c_cnt_w'(1);
          if (r_count == c_cnt_w'(WIDTH - 1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          quotient    <= w_q_fix;
          remainder   <= w_r_fix;
          div_by_zero <= r_dbz;
          overflow    <= r_ovf;
          done        <= 1'b1;
          busy        <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_divider.sv
// +----------------------------------------------------------------------+
// | tb_alu_divider : scoreboard bench for the iterative signed divider   |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_alu_divider;
  import alu_div_pkg::*;

  logic        clock    = 1'b0;
  logic        reset_n  = 1'b0;
  logic        start    = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor  = '0;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  logic prev_done = 1'b0;

  always #5 clock = ~clock;

  alu_divider #(.WIDTH(DIV_WIDTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   sa;
    int   sd;
    sa = $signed(a);
    sd = $signed(b);
    if (b == 16'h0) begin
      e.q   = 16'hFFFF;
      e.r   = a;
      e.dbz = 1'b1;
      e.ovf = 1'b0;
    end else begin
      e.q   = 16'(sa / sd);
      e.r   = 16'(sa % sd);
      e.dbz = 1'b0;
      e.ovf = (a == DIV_MOST_NEG) && (b == 16'hFFFF);
    end
    return e;
  endfunction

  // Results are compared whenever the DUT signals done
  always @(negedge clock) begin
    if (reset_n && done) begin : mon
      exp_t e;
      check("done_single_cycle", {31'b0, prev_done}, 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("quotient", {16'b0, quotient}, {16'b0, e.q});
        check("remainder", {16'b0, remainder}, {16'b0, e.r});
        check("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
        check("overflow", {31'b0, overflow}, {31'b0, e.ovf});
      end
    end
    prev_done = reset_n && done;
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb_q.push_back(model(a, b));
    @(posedge clock);
    #1;
    start = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done(input int exp_lat, input string tag);
    int lat = 0;
    do begin
      @(posedge clock);
      #1;
      lat++;
    end while (!done && lat < 40);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_in_done"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_quotient", {16'b0, quotient}, 32'd0);
    check("rst_remainder", {16'b0, remainder}, 32'd0);
    check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    issue(16'd100, 16'd7);             wait_done(17, "p100_p7");
    issue(-16'sd100, 16'd7);           wait_done(17, "m100_p7");
    issue(16'd100, -16'sd7);           wait_done(17, "p100_m7");
    issue(-16'sd100, -16'sd7);         wait_done(17, "m100_m7");
    issue(16'h8000, 16'hFFFF);         wait_done(17, "ovf");
    issue(16'd6, 16'd3);               wait_done(17, "after_ovf");
    issue(16'd5, 16'd0);               wait_done(1,  "dbz5");
    issue(16'h8000, 16'd0);            wait_done(1,  "dbz_mneg");

    // A second start while busy must be dropped
    issue(16'd9, 16'd2);
    repeat (4) @(posedge clock);
    #1;
    start    = 1'b1;
    dividend = 16'd50;
    divisor  = 16'd5;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(12, "ignored_start");
    repeat (25) @(posedge clock);
    #1;

    // Start raised in the done cycle is accepted
    issue(16'd200, 16'd7);             wait_done(17, "b2b_first");
    issue(16'd77, -16'sd3);            wait_done(17, "b2b_second");

    for (int i = 0; i < 4; i++) begin
      issue(16'($urandom), 16'($urandom_range(1, 16'hFFFF)));
      wait_done(17, "rand");
    end

    issue(16'd77, -16'sd3);            wait_done(17, "pre_reset");

    // Asynchronous reset in the middle of RUN
    issue(16'd1234, 16'd5);
    repeat (7) @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_quotient", {16'b0, quotient}, 32'd0);
    check("midrst_remainder", {16'b0, remainder}, 32'd0);
    check("midrst_dbz", {31'b0, div_by_zero}, 32'd0);
    check("midrst_ovf", {31'b0, overflow}, 32'd0);
    sb_q.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    issue(16'd1000, 16'd10);           wait_done(17, "post_reset");

    repeat (25) @(posedge clock);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
